// File: rtl/fmc_adc_tpg_pkg.sv
// rtl/fmc_adc_tpg_pkg.sv - shared types, constants and helpers for the ADC test-pattern generator
package fmc_adc_tpg_pkg;

  typedef enum logic [1:0] {TPG_TRIANGLE, TPG_RAMP, TPG_CONST, TPG_PRBS} t_tpg_mode;

  localparam logic [14:0]        c_TPG_PRBS_SEED = 15'h7FFF;
  localparam logic signed [15:0] c_TPG_MAX       = 16'sh7FFF;
  localparam logic signed [15:0] c_TPG_MIN       = -16'sh8000;

  // Triangle direction states
  localparam logic [0:0] c_DIR_UP   = 1'b0;
  localparam logic [0:0] c_DIR_DOWN = 1'b1;

  // Two's-complement negate where -(-32768) saturates to +32767
  function automatic logic [15:0] tpg_neg_sat(input logic [15:0] v);
    return (v == c_TPG_MIN) ? c_TPG_MAX : (~v + 16'd1);
  endfunction

  // Advance a PRBS-15 (x^15+x^14+1) register by n shifts
  function automatic logic [14:0] prbs15_adv(input logic [14:0] s, input int n);
    logic [14:0] r;
    r = s;
    for (int i = 0; i < n; i++) begin
      r = {r[13:0], r[14] ^ r[13]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fmc_adc_tpg_wave.sv
// rtl/fmc_adc_tpg_wave.sv - sample-rate divider, triangle direction FSM and waveform value register
// FMC_ADC_TPG_PRBS_EN adds the tick_o strobe used by the top-level LFSR.
module fmc_adc_tpg_wave
  import fmc_adc_tpg_pkg::*;
#(
  parameter int g_DIV_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   load_i,
  input  logic [15:0]            load_val_i,
  input  logic                   valid_i,
  input  t_tpg_mode              mode_i,
  input  logic [15:0]            step_i,
  input  logic [14:0]            limit_i,
  input  logic [15:0]            const_i,
  input  logic [g_DIV_WIDTH-1:0] div_i,
`ifdef FMC_ADC_TPG_PRBS_EN
  output logic                   tick_o,
`endif
  output logic [15:0]            value_o
);

  logic [15:0]            value_q, value_d;
  logic [0:0]             dir_q, dir_d;
  logic [g_DIV_WIDTH-1:0] cnt_q, cnt_d;

  logic [15:0]            base_value;
  logic [0:0]             base_dir;
  logic [0:0]             tri_dir;
  logic [g_DIV_WIDTH-1:0] base_cnt;
  logic                   tick;
  // 18 bits so that a full-scale value plus a full 16-bit step cannot wrap
  logic signed [17:0]     cur_s, lim_pos, lim_neg, step_s, sum_s;

  always_comb begin
    base_value = load_i ? load_val_i : value_q;
    base_dir   = load_i ? c_DIR_UP : dir_q;
    base_cnt   = load_i ? '0 : cnt_q;
    // >= so that lowering div below the running count ticks immediately
    tick       = valid_i && (base_cnt >= div_i);

    cnt_d = base_cnt;
    if (valid_i) begin
      cnt_d = tick ? '0 : base_cnt + g_DIV_WIDTH'(1);
    end

    cur_s   = 18'($signed(base_value));
    lim_pos = $signed({3'b000, limit_i});
    lim_neg = -lim_pos;
    step_s  = $signed({2'b00, step_i});
    tri_dir = ((cur_s > lim_pos) || (cur_s < lim_neg)) ? ~base_dir : base_dir;
    sum_s   = (tri_dir == c_DIR_UP) ? (cur_s + step_s) : (cur_s - step_s);

    value_d = base_value;
    dir_d   = base_dir;
    case (mode_i)
      TPG_TRIANGLE: begin
        if (tick) begin
          if (sum_s > 18'(c_TPG_MAX)) begin
            value_d = c_TPG_MAX;
            dir_d   = ~tri_dir;
          end else if (sum_s < 18'(c_TPG_MIN)) begin
            value_d = c_TPG_MIN;
            dir_d   = ~tri_dir;
          end else begin
            value_d = sum_s[15:0];
            dir_d   = tri_dir;
          end
        end
      end
      TPG_RAMP: begin
        if (tick) begin
          value_d = base_value + step_i;
        end
      end
      default: begin
        if (valid_i) begin
          value_d = const_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      value_q <= '0;
      dir_q   <= c_DIR_UP;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // The emitted sample is the post-update value of this tick
  assign value_o = value_d;
`ifdef FMC_ADC_TPG_PRBS_EN
  assign tick_o  = tick && !clr_i;
`endif

endmodule

// File: rtl/fmc_adc_test_pattern_gen.sv
// rtl/fmc_adc_test_pattern_gen.sv - ADC test-pattern source with serdes pass-through
// Define FMC_ADC_TPG_PRBS_EN to build the PRBS-15 pattern for mode 3 (otherwise mode 3 = constant).
module fmc_adc_test_pattern_gen
  import fmc_adc_tpg_pkg::*;
#(
  parameter int g_NUM_CHAN  = 4,
  parameter int g_DIV_WIDTH = 16
) (
  input  logic                    clk_fs_i,
  input  logic                    rst_fs_i,
  input  logic [16*g_NUM_CHAN-1:0] serdes_data_i,
  input  logic                    serdes_valid_i,
  input  logic                    tpg_en_i,
  input  logic [1:0]              tpg_mode_i,
  input  logic [15:0]             tpg_step_i,
  input  logic [14:0]             tpg_limit_i,
  input  logic [15:0]             tpg_const_i,
  input  logic [g_DIV_WIDTH-1:0]  tpg_div_i,
  input  logic                    tpg_inv_odd_i,
  output logic [16*g_NUM_CHAN-1:0] data_o,
  output logic                    valid_o
);

  localparam int c_W = 16 * g_NUM_CHAN;

  logic [c_W-1:0] data_q, data_d;
  logic           valid_q, valid_d;
  logic           en_q, en_d;
  logic [1:0]     mode_q, mode_d;

  t_tpg_mode      mode;
  logic           load;
  logic [15:0]    load_val;
  logic [15:0]    wave_value;
  logic [15:0]    ch_word;
  logic [c_W-1:0] pattern;

  assign mode     = t_tpg_mode'(tpg_mode_i);
  assign load     = (tpg_en_i && !en_q) || (tpg_mode_i != mode_q);
  assign load_val = ((mode == TPG_RAMP) || (mode == TPG_CONST)) ? tpg_const_i : 16'h0000;

`ifdef FMC_ADC_TPG_PRBS_EN
  logic        wave_tick;
  logic [14:0] prbs_q, prbs_d, prbs_base;
`endif

  fmc_adc_tpg_wave #(
    .g_DIV_WIDTH (g_DIV_WIDTH)
  ) u_wave (
    .clk_i      (clk_fs_i),
    .rst_i      (rst_fs_i),
    .clr_i      (!tpg_en_i),
    .load_i     (load),
    .load_val_i (load_val),
    .valid_i    (serdes_valid_i),
    .mode_i     (mode),
    .step_i     (tpg_step_i),
    .limit_i    (tpg_limit_i),
    .const_i    (tpg_const_i),
    .div_i      (tpg_div_i),
`ifdef FMC_ADC_TPG_PRBS_EN
    .tick_o     (wave_tick),
`endif
    .value_o    (wave_value)
  );

`ifdef FMC_ADC_TPG_PRBS_EN
  always_comb begin
    prbs_base = (!tpg_en_i || load) ? c_TPG_PRBS_SEED : prbs_q;
    prbs_d    = prbs_base;
    if (wave_tick && (mode == TPG_PRBS)) begin
      prbs_d = prbs15_adv(prbs_base, 1);
    end
  end

  always_ff @(posedge clk_fs_i) begin
    if (rst_fs_i) begin
      prbs_q <= c_TPG_PRBS_SEED;
    end else begin
      prbs_q <= prbs_d;
    end
  end
`endif

  always_comb begin
    pattern = '0;
    ch_word = '0;
    for (int ch = 0; ch < g_NUM_CHAN; ch++) begin
      ch_word = wave_value;
`ifdef FMC_ADC_TPG_PRBS_EN
      if (mode == TPG_PRBS) begin
        ch_word = {prbs15_adv(prbs_d, 4 * ch), 1'b0};
      end
`endif
      // Channels 2, 4, ... are the odd lane indices
      if (tpg_inv_odd_i && ch[0]) begin
        ch_word = tpg_neg_sat(ch_word);
      end
      pattern[16*ch +: 16] = ch_word;
    end
  end

  always_comb begin
    data_d = data_q;
    if (!tpg_en_i) begin
      data_d = serdes_data_i;
    end else if (serdes_valid_i) begin
      data_d = pattern;
    end
    valid_d = serdes_valid_i;
    en_d    = tpg_en_i;
    mode_d  = tpg_mode_i;
  end

  always_ff @(posedge clk_fs_i) begin
    if (rst_fs_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      en_q    <= 1'b0;
      mode_q  <= 2'd0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_fmc_adc_test_pattern_gen.sv
// tb/tb_fmc_adc_test_pattern_gen.sv - self-checking bench for fmc_adc_test_pattern_gen (default build, FMC_ADC_TPG_PRBS_EN undefined)
module tb_fmc_adc_test_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_fs_i;
  logic [63:0] serdes_data_i;
  logic        serdes_valid_i;
  logic        tpg_en_i;
  logic [1:0]  tpg_mode_i;
  logic [15:0] tpg_step_i;
  logic [14:0] tpg_limit_i;
  logic [15:0] tpg_const_i;
  logic [15:0] tpg_div_i;
  logic        tpg_inv_odd_i;
  logic [63:0] data_o;
  logic        valid_o;

  always #5 clk = ~clk;

  fmc_adc_test_pattern_gen dut (
    .clk_fs_i       (clk),
    .rst_fs_i       (rst_fs_i),
    .serdes_data_i  (serdes_data_i),
    .serdes_valid_i (serdes_valid_i),
    .tpg_en_i       (tpg_en_i),
    .tpg_mode_i     (tpg_mode_i),
    .tpg_step_i     (tpg_step_i),
    .tpg_limit_i    (tpg_limit_i),
    .tpg_const_i    (tpg_const_i),
    .tpg_div_i      (tpg_div_i),
    .tpg_inv_odd_i  (tpg_inv_odd_i),
    .data_o         (data_o),
    .valid_o        (valid_o)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: waveform value as an integer, direction as +1/-1 flag
  int          m_val;
  bit          m_up;
  int          m_cnt;
  bit          m_en_prev;
  logic [1:0]  m_mode_prev;
  logic [63:0] m_data;
  bit          m_valid;
  bit          m_cap;

  logic [63:0] exp_data;
  bit          exp_valid;
  bit          exp_cap;
  bit          exp_on = 1'b0;
  logic [15:0] cap[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void chk_cap(string name, int idx, logic [15:0] req);
    logic [15:0] act;
    act = 'x;
    if (idx < cap.size()) act = cap[idx];
    check(name, 64'(act), 64'(req));
  endfunction

  function automatic int s16(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic logic [63:0] pack(input int v, input bit inv);
    logic [63:0] w;
    int c;
    w = '0;
    for (int ch = 0; ch < 4; ch++) begin
      c = v;
      if (inv && (ch % 2 == 1)) c = (v == -32768) ? 32767 : -v;
      w[16*ch +: 16] = c[15:0];
    end
    return w;
  endfunction

  task automatic model_cycle();
    bit tick;
    int s;
    m_cap = 1'b0;
    if (rst_fs_i) begin
      m_val = 0; m_up = 1'b1; m_cnt = 0; m_en_prev = 1'b0; m_mode_prev = 2'd0;
      m_data = '0; m_valid = 1'b0;
      return;
    end
    m_valid = serdes_valid_i;
    if (!tpg_en_i) begin
      m_data = serdes_data_i;
      m_val = 0; m_up = 1'b1; m_cnt = 0;
    end else begin
      if (!m_en_prev || (tpg_mode_i != m_mode_prev)) begin
        m_val = ((tpg_mode_i == 2'd1) || (tpg_mode_i == 2'd2)) ? s16(tpg_const_i) : 0;
        m_up = 1'b1;
        m_cnt = 0;
      end
      if (serdes_valid_i) begin
        tick  = (m_cnt >= int'(tpg_div_i));
        m_cnt = tick ? 0 : m_cnt + 1;
        case (tpg_mode_i)
          2'd0: if (tick) begin
            if ((m_val > int'(tpg_limit_i)) || (m_val < -int'(tpg_limit_i))) m_up = !m_up;
            s = m_up ? m_val + int'(tpg_step_i) : m_val - int'(tpg_step_i);
            if (s > 32767) begin
              s = 32767; m_up = !m_up;
            end else if (s < -32768) begin
              s = -32768; m_up = !m_up;
            end
            m_val = s;
          end
          2'd1: if (tick) m_val = s16(16'(m_val + int'(tpg_step_i)));
          default: m_val = s16(tpg_const_i);
        endcase
        m_data = pack(m_val, tpg_inv_odd_i);
        m_cap  = 1'b1;
      end
    end
    m_en_prev   = tpg_en_i;
    m_mode_prev = tpg_mode_i;
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      check("valid_o", 64'(valid_o), 64'(exp_valid));
      check("data_o", data_o, exp_data);
      if (exp_cap) cap.push_back(data_o[15:0]);
    end
  end

  task automatic cyc();
    model_cycle();
    @(posedge clk);
    #1;
    exp_data  = m_data;
    exp_valid = m_valid;
    exp_cap   = m_cap;
    exp_on    = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      serdes_valid_i = (gap == 0) ? 1'b1 : ((i % gap) != gap - 1);
      serdes_data_i  = {$urandom, $urandom};
      cyc();
    end
  endtask

  initial begin
    rst_fs_i = 1'b1; serdes_data_i = '0; serdes_valid_i = 1'b0;
    tpg_en_i = 1'b0; tpg_mode_i = 2'd0; tpg_step_i = '0; tpg_limit_i = '0;
    tpg_const_i = '0; tpg_div_i = '0; tpg_inv_odd_i = 1'b0;
    run(3, 0);
    rst_fs_i = 1'b0;
    check("reset_data", data_o, 64'h0);
    check("reset_valid", 64'(valid_o), 64'h0);

    // Triangle, step 8, limit 400
    tpg_en_i = 1'b1; tpg_mode_i = 2'd0; tpg_step_i = 16'd8; tpg_limit_i = 15'd400; tpg_div_i = 16'd0;
    cap.delete();
    run(260, 0);
    chk_cap("tri_first", 0, 16'd8);
    chk_cap("tri_peak", 50, 16'd408);
    chk_cap("tri_turn", 51, 16'd400);
    chk_cap("tri_trough", 152, 16'hFE68);
    chk_cap("tri_turn_up", 153, 16'hFE70);
    chk_cap("tri_period", 204, 16'd8);
    tpg_step_i = 16'd3;
    run(30, 0);
    tpg_limit_i = 15'd100;
    run(40, 0);

    // Ramp through the divider with gaps, then lower div below the count
    tpg_mode_i = 2'd1; tpg_const_i = 16'd0; tpg_step_i = 16'd1; tpg_div_i = 16'd3;
    cap.delete();
    run(24, 3);
    chk_cap("div_hold0", 2, 16'd0);
    chk_cap("div_first_tick", 3, 16'd1);
    chk_cap("div_hold1", 6, 16'd1);
    chk_cap("div_second_tick", 7, 16'd2);
    cap.delete();
    run(2, 0);
    tpg_div_i = 16'd1;
    run(4, 0);
    chk_cap("div_lower_hold", 1, 16'd4);
    chk_cap("div_lower_tick", 2, 16'd5);

    // Triangle saturation
    tpg_mode_i = 2'd0; tpg_step_i = 16'h4000; tpg_limit_i = 15'h7FFF; tpg_div_i = 16'd0;
    cap.delete();
    run(8, 0);
    chk_cap("sat_up", 0, 16'h4000);
    chk_cap("sat_max", 1, 16'h7FFF);
    chk_cap("sat_down", 2, 16'h3FFF);
    chk_cap("sat_neg1", 3, 16'hFFFF);
    chk_cap("sat_min", 5, 16'h8000);
    chk_cap("sat_min_hold", 6, 16'h8000);

    // Ramp wrap
    tpg_mode_i = 2'd1; tpg_const_i = 16'h7FFF; tpg_step_i = 16'd1;
    cap.delete();
    run(3, 0);
    chk_cap("ramp_wrap", 0, 16'h8000);
    chk_cap("ramp_wrap_next", 1, 16'h8001);

    // Pass-through and reload on re-enable
    tpg_mode_i = 2'd0; tpg_step_i = 16'd8; tpg_limit_i = 15'd400;
    run(20, 0);
    tpg_en_i = 1'b0;
    serdes_data_i = 64'hDEAD_BEEF_0123_4567; serdes_valid_i = 1'b0;
    cyc();
    check("pass_literal", data_o, 64'hDEAD_BEEF_0123_4567);
    run(10, 2);
    tpg_en_i = 1'b1;
    cap.delete();
    run(5, 0);
    chk_cap("reenable_first", 0, 16'd8);
    chk_cap("reenable_second", 1, 16'd16);

    // Inversion of odd channels, and mode 3 as constant
    tpg_mode_i = 2'd2; tpg_const_i = 16'h8000; tpg_inv_odd_i = 1'b1; serdes_valid_i = 1'b1;
    cyc();
    check("inv_min", data_o, 64'h7FFF_8000_7FFF_8000);
    tpg_const_i = 16'd5;
    cyc();
    check("inv_five", data_o, 64'hFFFB_0005_FFFB_0005);
    tpg_mode_i = 2'd3; tpg_const_i = 16'h1234; tpg_inv_odd_i = 1'b0;
    cyc();
    check("mode3_const", data_o, 64'h1234_1234_1234_1234);
    run(6, 2);

    // Reset mid-operation
    tpg_mode_i = 2'd0;
    run(10, 0);
    rst_fs_i = 1'b1; serdes_valid_i = 1'b1;
    cyc();
    check("midrst_data", data_o, 64'h0);
    check("midrst_valid", 64'(valid_o), 64'h0);
    rst_fs_i = 1'b0;
    cap.delete();
    run(3, 0);
    chk_cap("after_rst_first", 0, 16'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
